// File: rtl/uart_bus_loader_if.sv
// Memory-bus signals between the UART loader (initiator) and the memory/peripheral side.
interface uart_bus_loader_if;
  logic [15:0] address;
  logic [31:0] w_data;
  logic        we;
  logic [31:0] r_data;

  modport master (output address, output w_data, output we, input r_data);
  modport slave  (input address, input w_data, input we, output r_data);
endinterface

// File: rtl/uart_bus_loader.sv
// UART-driven bus initiator: 8N1 RX/TX at 16x oversampling, command frames turn into
// single-cycle bus writes or bus reads whose word is returned MSB first over TX.
module uart_bus_loader #(
  parameter int CLKS_PER_TICK = 27,
  parameter int TIMEOUT_TICKS = 5120
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_Rx,
  output logic                     o_Tx,
  uart_bus_loader_if.master        bus,
  output logic                     busy,
  output logic                     frame_err
);
  localparam int TCW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int TOW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  // ---------------- oversampling tick ----------------
  logic [TCW-1:0] tick_cnt;
  logic           tick;
  assign tick = (tick_cnt == TCW'(CLKS_PER_TICK - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TCW'(1);

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t   rx_state, rx_state_n;
  logic        rx_s1, rx_s2, rx_s3;
  logic [3:0]  rx_tck;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_done, rx_err, rx_mid;
  assign rx_mid = tick && (rx_tck == 4'd15);

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_s3 && !rx_s2) rx_state_n = RX_START;
      RX_START: if (tick && rx_tck == 4'd7) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_mid && rx_bit == 3'd7) rx_state_n = RX_STOP;
      RX_STOP:  if (rx_mid) rx_state_n = RX_IDLE;
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
      rx_tck <= '0; rx_bit <= '0; rx_sh <= '0;
      rx_done <= 1'b0; rx_err <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_s1 <= i_Rx; rx_s2 <= rx_s1; rx_s3 <= rx_s2;
      rx_done <= (rx_state == RX_STOP) && rx_mid && rx_s2;
      rx_err  <= (rx_state == RX_STOP) && rx_mid && !rx_s2;
      // bit timing restarts from zero on every state change (start edge, mid start bit)
      if (rx_state != rx_state_n) rx_tck <= '0;
      else if (tick)              rx_tck <= rx_tck + 4'd1;
      if (rx_state == RX_IDLE) rx_bit <= '0;
      else if (rx_state == RX_DATA && rx_mid) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end

  // ---------------- transmitter ----------------
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
  tx_state_t  tx_state, tx_state_n;
  logic [8:0] tx_sh;
  logic [3:0] tx_tck, tx_bit;
  logic [7:0] tx_data;
  logic       tx_start, tx_done, tx_bit_end;
  assign tx_bit_end = tick && (tx_tck == 4'd15);

  always_comb begin
    tx_state_n = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_start) tx_state_n = TX_BUSY;
      TX_BUSY: if (tx_bit_end && tx_bit == 4'd9) tx_state_n = TX_IDLE;
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      o_Tx <= 1'b1;
      tx_sh <= '1; tx_tck <= '0; tx_bit <= '0;
      tx_done <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_done  <= (tx_state == TX_BUSY) && (tx_state_n == TX_IDLE);
      if (tx_state == TX_IDLE) begin
        if (tx_start) begin
          tx_sh <= {1'b1, tx_data};
          o_Tx <= 1'b0;
          tx_tck <= '0; tx_bit <= '0;
        end
      end else if (tick) begin
        tx_tck <= tx_tck + 4'd1;
        // bit 9 is the stop bit; the line is already high, just let it run out
        if (tx_tck == 4'd15 && tx_bit != 4'd9) begin
          o_Tx  <= tx_sh[0];
          tx_sh <= {1'b1, tx_sh[8:1]};
          tx_bit <= tx_bit + 4'd1;
        end
      end
    end

  // ---------------- frame FSM ----------------
  typedef enum logic [2:0] {F_IDLE, F_GET_AH, F_GET_AL, F_GET_D,
                            F_DO_WR, F_RD_ADDR, F_RD_CAP, F_SEND} f_state_t;
  f_state_t       f_state, f_state_n;
  logic [TOW-1:0] to_cnt;
  logic           in_get, timeout, is_wr, send_pend;
  logic [1:0]     d_cnt;
  logic [2:0]     bytes_left;
  logic [31:0]    tx_buf, wdata_q;
  logic [15:0]    addr_q;

  assign in_get   = f_state inside {F_GET_AH, F_GET_AL, F_GET_D};
  assign timeout  = in_get && tick && (to_cnt == TOW'(TIMEOUT_TICKS - 1));
  assign tx_data  = tx_buf[31:24];
  assign tx_start = (f_state == F_SEND) && send_pend && (tx_state == TX_IDLE);
  assign bus.we      = (f_state == F_DO_WR);
  assign bus.address = addr_q;
  assign bus.w_data  = wdata_q;

  always_comb begin
    f_state_n = f_state;
    case (f_state)
      F_IDLE:    if (rx_done) f_state_n = (rx_sh == CMD_W || rx_sh == CMD_R) ? F_GET_AH : F_SEND;
      F_GET_AH:  if (rx_done) f_state_n = F_GET_AL;
      F_GET_AL:  if (rx_done) f_state_n = is_wr ? F_GET_D : F_RD_ADDR;
      F_GET_D:   if (rx_done && d_cnt == 2'd3) f_state_n = F_DO_WR;
      F_DO_WR:   f_state_n = F_SEND;
      F_RD_ADDR: f_state_n = F_RD_CAP;
      F_RD_CAP:  f_state_n = F_SEND;
      F_SEND:    if (tx_done && bytes_left == 3'd1) f_state_n = F_IDLE;
      default:   f_state_n = F_IDLE;
    endcase
    // a broken or stalled byte stream abandons the frame being collected
    if (in_get && (timeout || rx_err)) f_state_n = F_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      f_state <= F_IDLE;
      busy <= 1'b0; frame_err <= 1'b0;
      to_cnt <= '0; is_wr <= 1'b0; d_cnt <= '0;
      tx_buf <= '0; bytes_left <= '0; send_pend <= 1'b0;
      addr_q <= '0; wdata_q <= '0;
    end else begin
      f_state   <= f_state_n;
      busy      <= (f_state_n != F_IDLE);
      frame_err <= rx_err | timeout;
      if (!in_get || rx_done) to_cnt <= '0;
      else if (tick)          to_cnt <= to_cnt + TOW'(1);
      case (f_state)
        F_IDLE: if (rx_done) begin
          is_wr <= (rx_sh == CMD_W);
          if (rx_sh != CMD_W && rx_sh != CMD_R) begin
            tx_buf <= {NAK, 24'h0}; bytes_left <= 3'd1; send_pend <= 1'b1;
          end
        end
        F_GET_AH: if (rx_done) addr_q[15:8] <= rx_sh;
        F_GET_AL: if (rx_done) begin addr_q[7:0] <= rx_sh; d_cnt <= '0; end
        F_GET_D:  if (rx_done) begin wdata_q <= {wdata_q[23:0], rx_sh}; d_cnt <= d_cnt + 2'd1; end
        F_DO_WR:  begin tx_buf <= {ACK, 24'h0}; bytes_left <= 3'd1; send_pend <= 1'b1; end
        F_RD_CAP: begin tx_buf <= bus.r_data; bytes_left <= 3'd4; send_pend <= 1'b1; end
        F_SEND: begin
          if (tx_start) send_pend <= 1'b0;
          if (tx_done) begin
            tx_buf     <= {tx_buf[23:0], 8'h00};
            bytes_left <= bytes_left - 3'd1;
            send_pend  <= (bytes_left != 3'd1);
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_uart_bus_loader.sv
// Scoreboard bench: stimulus pushes expected bus writes, TX bytes and frame errors;
// independent monitors pop and compare as the loader produces them.
module tb_uart_bus_loader;
  localparam int CPT = 4;
  localparam int TO  = 400;
  localparam int BIT = 16 * CPT;

  typedef struct packed { logic [15:0] a; logic [31:0] d; } wr_t;

  logic clk = 1'b0;
  logic rst_n, i_rx, o_tx, busy, frame_err;
  uart_bus_loader_if bus();

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int         exp_ferr = 0;
  int         checks = 0;
  int         errors = 0;

  assign bus.r_data = (bus.address == 16'h0014) ? 32'h12345678 : 32'hCAFEF00D;

  uart_bus_loader #(.CLKS_PER_TICK(CPT), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_Rx(i_rx), .o_Tx(o_tx),
    .bus(bus), .busy(busy), .frame_err(frame_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    i_rx = 1'b0; repeat (BIT) @(negedge clk);
    for (int k = 0; k < 8; k++) begin i_rx = b[k]; repeat (BIT) @(negedge clk); end
    i_rx = stop_bit; repeat (BIT) @(negedge clk);
    i_rx = 1'b1;
  endtask

  task automatic write_frame(input logic [15:0] a, input logic [31:0] d);
    exp_wr.push_back('{a: a, d: d});
    exp_tx.push_back(8'h06);
    rx_byte(8'h57); rx_byte(a[15:8]); rx_byte(a[7:0]);
    rx_byte(d[31:24]); rx_byte(d[23:16]); rx_byte(d[15:8]); rx_byte(d[7:0]);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 20000) begin @(negedge clk); n++; end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  // bus write monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.we) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL we_unexpected: got addr %h data %h expected no write", bus.address, bus.w_data);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        if (bus.address !== e.a || bus.w_data !== e.d) begin
          errors++;
          $display("FAIL we_write: got addr %h data %h expected addr %h data %h",
                   bus.address, bus.w_data, e.a, e.d);
        end
      end
    end
  end

  // frame_err monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && frame_err) begin
      checks++;
      if (exp_ferr == 0) begin
        errors++;
        $display("FAIL frame_err_unexpected: got 1 expected 0");
      end else exp_ferr--;
    end
  end

  // serial TX decoder; a byte interrupted by reset is dropped
  initial begin : tx_mon
    logic prev, ab, stop_bit;
    logic [7:0] rb;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !o_tx) begin
        ab = 1'b0; rb = '0; stop_bit = 1'b0;
        for (int k = 0; k < 10; k++) begin
          for (int c = 0; c < ((k == 0) ? BIT / 2 : BIT); c++) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
          end
          if (k >= 1 && k <= 8) rb[k-1] = o_tx;
          if (k == 9) stop_bit = o_tx;
        end
        if (!ab) begin
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got byte %h expected none", rb);
          end else begin
            logic [7:0] e;
            e = exp_tx.pop_front();
            if (rb !== e || stop_bit !== 1'b1) begin
              errors++;
              $display("FAIL tx_byte: got %h stop %b expected %h stop 1", rb, stop_bit, e);
            end
          end
        end
      end
      prev = o_tx;
    end
  end

  initial begin
    #(900000 * 10);
    $display("FAIL watchdog: got no finish expected finish within budget");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, o_tx}, 32'd1);
    chk("rst_we", {31'd0, bus.we}, 32'd0);
    chk("rst_addr", {16'd0, bus.address}, 32'd0);
    chk("rst_wdata", bus.w_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (5 * BIT) @(negedge clk);

    // T1 write
    write_frame(16'h0010, 32'hDEADBEEF);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_idle("t1_idle");

    // T2 read
    exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
    rx_byte(8'h52); rx_byte(8'h00); rx_byte(8'h14);
    chk("t2_addr", {16'd0, bus.address}, 32'h0014);
    chk("t2_wdata_hold", bus.w_data, 32'hDEADBEEF);
    wait_idle("t2_idle");

    // T3 bad command, then a normal write
    exp_tx.push_back(8'h15);
    rx_byte(8'h41);
    wait_idle("t3_idle");
    write_frame(16'h0020, 32'h01020304);
    wait_idle("t3_wr_idle");

    // T4 stop-bit error on the second byte
    exp_ferr++;
    rx_byte(8'h57); rx_byte(8'h00, 1'b0);
    repeat (BIT) @(negedge clk);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    write_frame(16'h0030, 32'hA5A55A5A);
    wait_idle("t4_wr_idle");

    // T5 inter-byte timeout
    exp_ferr++;
    rx_byte(8'h57); rx_byte(8'h00);
    chk("t5_busy_pre", {31'd0, busy}, 32'd1);
    repeat ((TO + 100) * CPT) @(negedge clk);
    chk("t5_busy_post", {31'd0, busy}, 32'd0);
    write_frame(16'h0040, 32'h0BADF00D);
    wait_idle("t5_wr_idle");

    // T6 reset in the middle of the first reply byte of a read
    rx_byte(8'h52); rx_byte(8'h00); rx_byte(8'h14);
    repeat (2 * BIT) @(negedge clk);
    chk("t6_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_tx_rst", {31'd0, o_tx}, 32'd1);
    chk("t6_busy_rst", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    write_frame(16'h0050, 32'h89ABCDEF);
    wait_idle("t6_wr_idle");

    repeat (2 * BIT) @(negedge clk);
    chk("left_wr", exp_wr.size(), 32'd0);
    chk("left_tx", exp_tx.size(), 32'd0);
    chk("left_ferr", exp_ferr, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
